vj_window_scan_ctrl: RTL and testbench

//  Raster-scans 19x19 detection windows over an integral-image frame and sequences vj_cascade_eval_19x19_4stage,
//  one window at a time (start/done handshake). Passing windows are queued in a detection FIFO read by host/NMS logic.

---
 rtl/vj_pkg.sv | 34 +++
 rtl/vj_det_fifo.sv | 75 +++++++
 rtl/vj_window_scan_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_vj_window_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vj_pkg.sv
// Shared widths, detection record and scan FSM encoding for the Viola-Jones window scanner.
package vj_pkg;

    localparam int VJ_WIN_X_W = 10;
    localparam int VJ_WIN_Y_W = 9;
    localparam int VJ_SCORE_W = 32;
    localparam int VJ_WCNT_W  = 20;
    localparam int VJ_DCNT_W  = 16;

    typedef struct packed {
        logic [VJ_WIN_X_W-1:0] x;
        logic [VJ_WIN_Y_W-1:0] y;
        logic [VJ_SCORE_W-1:0] score;
    } vj_det_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ADV   = 3'd3,
        S_FIN   = 3'd4
    } vj_state_e;

    function automatic logic [VJ_WCNT_W-1:0] sat_inc_w(input logic [VJ_WCNT_W-1:0] v);
        if (v == {VJ_WCNT_W{1'b1}}) return v;
        else return v + VJ_WCNT_W'(1);
    endfunction

    function automatic logic [VJ_DCNT_W-1:0] sat_inc_d(input logic [VJ_DCNT_W-1:0] v);
        if (v == {VJ_DCNT_W{1'b1}}) return v;
        else return v + VJ_DCNT_W'(1);
    endfunction

endpackage

// File: rtl/vj_det_fifo.sv
// Detection record FIFO: first-word-fall-through with a registered head; a push
// into a full FIFO is accepted when a pop happens in the same cycle.
module vj_det_fifo
    import vj_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push_i,
    input  vj_det_t wr_data_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    valid_o,
    output vj_det_t head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    vj_det_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    vj_det_t         head_q, head_d;
    logic            valid_q;

    // Pointer, occupancy and head next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        else        wr_ptr_d = wr_ptr_q;
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        else        rd_ptr_d = rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // The incoming record becomes head when nothing older survives this cycle.
        if (push_i && ((cnt_q == CW'(0)) || ((cnt_q == CW'(1)) && pop_i))) head_d = wr_data_i;
        else if (pop_i && (cnt_q > CW'(1)))                                 head_d = mem_q[rd_ptr_d];
        else                                                                head_d = head_q;
    end

    // Control and head registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            valid_q  <= (cnt_d != CW'(0));
        end
    end

    // Record storage
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign valid_o = valid_q;
    assign head_o  = head_q;

endmodule

// File: rtl/vj_window_scan_ctrl.sv
// Raster-scans detection windows over a frame, handshakes each with the cascade
// evaluator and queues passing windows in the detection FIFO.
module vj_window_scan_ctrl
    import vj_pkg::*;
#(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int WIN       = 19,
    parameter int STEP      = 1,
    parameter int DET_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         frame_start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         aborted,
    output logic                         eval_start,
    output logic [VJ_WIN_X_W-1:0]        eval_win_x,
    output logic [VJ_WIN_Y_W-1:0]        eval_win_y,
    input  logic                         eval_done,
    input  logic                         eval_pass,
    input  logic signed [VJ_SCORE_W-1:0] eval_score,
    output logic                         det_valid,
    input  logic                         det_ready,
    output logic [VJ_WIN_X_W-1:0]        det_x,
    output logic [VJ_WIN_Y_W-1:0]        det_y,
    output logic signed [VJ_SCORE_W-1:0] det_score,
    output logic [VJ_WCNT_W-1:0]         win_count,
    output logic [VJ_DCNT_W-1:0]         det_count,
    output logic [VJ_DCNT_W-1:0]         drop_count
);

    localparam int X_LAST = IMG_W - WIN;
    localparam int Y_LAST = IMG_H - WIN;

    vj_state_e              state_q, state_d;
    logic [VJ_WIN_X_W-1:0]  x_q, x_d;
    logic [VJ_WIN_Y_W-1:0]  y_q, y_d;
    logic                   abort_pend_q, abort_pend_d;
    logic                   aborted_q, aborted_d;
    logic                   busy_q, frame_done_q, eval_start_q;
    logic [VJ_WCNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [VJ_DCNT_W-1:0]   det_cnt_q, det_cnt_d;
    logic [VJ_DCNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [VJ_WIN_X_W:0]    x_nxt_s;
    logic [VJ_WIN_Y_W:0]    y_nxt_s;
    logic                   res_evt_s, pass_evt_s, push_s, drop_s, pop_s, abort_set_s;
    logic                   fifo_full_s, fifo_valid_s;
    vj_det_t                push_rec_s, head_rec_s;

    // One extra bit on the coordinate adds so the edge test can never wrap.
    assign x_nxt_s     = {1'b0, x_q} + (VJ_WIN_X_W+1)'(STEP);
    assign y_nxt_s     = {1'b0, y_q} + (VJ_WIN_Y_W+1)'(STEP);
    assign pop_s       = fifo_valid_s & det_ready;
    assign res_evt_s   = (state_q == S_WAIT) & eval_done;
    assign pass_evt_s  = res_evt_s & eval_pass;
    assign push_s      = pass_evt_s & (~fifo_full_s | pop_s);
    assign drop_s      = pass_evt_s & fifo_full_s & ~pop_s;
    assign abort_set_s = abort & busy_q;
    assign push_rec_s  = '{x: x_q, y: y_q, score: eval_score};

    // Scan sequencing, coordinates, abort bookkeeping and per-scan counters
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        abort_pend_d = abort_pend_q | abort_set_s;
        aborted_d    = aborted_q;
        win_cnt_d    = win_cnt_q;
        det_cnt_d    = det_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    x_d          = '0;
                    y_d          = '0;
                    win_cnt_d    = '0;
                    det_cnt_d    = '0;
                    drop_cnt_d   = '0;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    state_d      = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (eval_done) begin
                    win_cnt_d = sat_inc_w(win_cnt_q);
                    if (push_s)      det_cnt_d  = sat_inc_d(det_cnt_q);
                    else             det_cnt_d  = det_cnt_q;
                    if (drop_s)      drop_cnt_d = sat_inc_d(drop_cnt_q);
                    else             drop_cnt_d = drop_cnt_q;
                    state_d = S_ADV;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ADV: begin
                if (abort_pend_q) begin
                    state_d = S_FIN;
                end else if (x_nxt_s <= (VJ_WIN_X_W+1)'(X_LAST)) begin
                    x_d     = x_nxt_s[VJ_WIN_X_W-1:0];
                    state_d = S_ISSUE;
                end else if (y_nxt_s <= (VJ_WIN_Y_W+1)'(Y_LAST)) begin
                    x_d     = '0;
                    y_d     = y_nxt_s[VJ_WIN_Y_W-1:0];
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_FIN;
                end
                // Latch the outcome on entry so it is valid alongside frame_done.
                if (state_d == S_FIN) aborted_d = abort_pend_q | abort_set_s;
                else                  aborted_d = aborted_q;
            end
            S_FIN: begin
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                abort_pend_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State, counters and registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            eval_start_q <= 1'b0;
            win_cnt_q    <= '0;
            det_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
            busy_q       <= (state_d == S_ISSUE) | (state_d == S_WAIT) | (state_d == S_ADV);
            frame_done_q <= (state_d == S_FIN);
            eval_start_q <= (state_d == S_ISSUE);
            win_cnt_q    <= win_cnt_d;
            det_cnt_q    <= det_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    vj_det_fifo #(
        .DEPTH(DET_DEPTH)
    ) u_det_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_i   (push_s),
        .wr_data_i(push_rec_s),
        .pop_i    (pop_s),
        .full_o   (fifo_full_s),
        .valid_o  (fifo_valid_s),
        .head_o   (head_rec_s)
    );

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign aborted    = aborted_q;
    assign eval_start = eval_start_q;
    assign eval_win_x = x_q;
    assign eval_win_y = y_q;
    assign det_valid  = fifo_valid_s;
    assign det_x      = head_rec_s.x;
    assign det_y      = head_rec_s.y;
    assign det_score  = head_rec_s.score;
    assign win_count  = win_cnt_q;
    assign det_count  = det_cnt_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_vj_window_scan_ctrl.sv
// Directed bench for the window scanner on a 23x21 frame, stride 2, two-entry detection FIFO.
module tb_vj_window_scan_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_start = 1'b0;
    logic abort = 1'b0;
    logic eval_done = 1'b0;
    logic eval_pass = 1'b0;
    logic det_ready = 1'b0;
    logic signed [31:0] eval_score = 32'sd0;
    logic busy, frame_done, aborted, eval_start, det_valid;
    logic [9:0] eval_win_x, det_x;
    logic [8:0] eval_win_y, det_y;
    logic signed [31:0] det_score;
    logic [19:0] win_count;
    logic [15:0] det_count, drop_count;

    int n_checks = 0;
    int n_errors = 0;
    int pass_mode = 0;
    int n_win = 0;
    int n_done = 0;
    int base_win, base_done;
    int log_x [64];
    int log_y [64];
    int exp_x [6] = '{0, 2, 4, 0, 2, 4};
    int exp_y [6] = '{0, 0, 0, 2, 2, 2};

    vj_window_scan_ctrl #(
        .IMG_W(23), .IMG_H(21), .WIN(19), .STEP(2), .DET_DEPTH(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .abort(abort),
        .busy(busy), .frame_done(frame_done), .aborted(aborted),
        .eval_start(eval_start), .eval_win_x(eval_win_x), .eval_win_y(eval_win_y),
        .eval_done(eval_done), .eval_pass(eval_pass), .eval_score(eval_score),
        .det_valid(det_valid), .det_ready(det_ready), .det_x(det_x), .det_y(det_y),
        .det_score(det_score), .win_count(win_count), .det_count(det_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Evaluator model: done 5 cycles after each eval_start; reset cancels the pending result.
    initial begin : eval_model
        int  cx, cy;
        bit  killed;
        forever begin
            @(negedge clk);
            if (eval_start && reset_n) begin
                cx = int'(eval_win_x);
                cy = int'(eval_win_y);
                if (n_win < 64) begin
                    log_x[n_win] = cx;
                    log_y[n_win] = cy;
                end
                n_win++;
                killed = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (!reset_n) killed = 1'b1;
                end
                if (!killed) begin
                    eval_done = 1'b1;
                    case (pass_mode)
                        1: begin
                            eval_pass  = (cx == 2) && (cy == 2);
                            eval_score = -32'sd7;
                        end
                        2: begin
                            eval_pass  = 1'b1;
                            eval_score = 32'(cx * 100 + cy + 1);
                        end
                        default: begin
                            eval_pass  = 1'b0;
                            eval_score = 32'sd0;
                        end
                    endcase
                    @(negedge clk);
                    eval_done = 1'b0;
                    eval_pass = 1'b0;
                end
            end
        end
    end

    // frame_done pulse counter
    always @(negedge clk) begin
        if (frame_done) n_done <= n_done + 1;
    end

    task automatic start_scan();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_start_at(input int wx, input int wy, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (eval_start && (int'(eval_win_x) == wx) && (int'(eval_win_y) == wy)) seen = 1'b1;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic pop_one();
        @(negedge clk);
        det_ready = 1'b1;
        @(negedge clk);
        det_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(frame_done), 32'd0);
        check_eq("rst_evstart", 32'(eval_start), 32'd0);
        check_eq("rst_detvalid", 32'(det_valid), 32'd0);
        check_eq("rst_wincnt", 32'(win_count), 32'd0);
        reset_n = 1'b1;

        // A: no passes, full raster, start ignored while busy
        base_win = n_win; base_done = n_done; pass_mode = 0;
        start_scan();
        check_eq("A_latency", 32'(eval_start), 32'd1);
        check_eq("A_busy", 32'(busy), 32'd1);
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        wait_done("A_done_seen");
        check_eq("A_busy_at_done", 32'(busy), 32'd0);
        check_eq("A_aborted", 32'(aborted), 32'd0);
        check_eq("A_wincnt", 32'(win_count), 32'd6);
        repeat (3) @(negedge clk);
        check_eq("A_done_pulses", 32'(n_done - base_done), 32'd1);
        check_eq("A_nwin", 32'(n_win - base_win), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("A_x%0d", i), 32'(log_x[base_win + i]), 32'(exp_x[i]));
            check_eq($sformatf("A_y%0d", i), 32'(log_y[base_win + i]), 32'(exp_y[i]));
        end

        // B: single pass at (2,2)
        pass_mode = 1;
        start_scan();
        wait_done("B_done_seen");
        check_eq("B_valid", 32'(det_valid), 32'd1);
        check_eq("B_x", 32'(det_x), 32'd2);
        check_eq("B_y", 32'(det_y), 32'd2);
        check_eq("B_score", 32'(det_score), 32'hFFFF_FFF9);
        check_eq("B_detcnt", 32'(det_count), 32'd1);
        check_eq("B_dropcnt", 32'(drop_count), 32'd0);
        pop_one();
        check_eq("B_empty", 32'(det_valid), 32'd0);
        check_eq("B_x_hold", 32'(det_x), 32'd2);

        // C: all pass, no consumer -> two kept, four dropped
        pass_mode = 2;
        start_scan();
        wait_done("C_done_seen");
        check_eq("C_dropcnt", 32'(drop_count), 32'd4);
        check_eq("C_detcnt", 32'(det_count), 32'd2);
        check_eq("C_h0_x", 32'(det_x), 32'd0);
        check_eq("C_h0_score", 32'(det_score), 32'd1);
        pop_one();
        check_eq("C_h1_x", 32'(det_x), 32'd2);
        check_eq("C_h1_score", 32'(det_score), 32'd201);
        pop_one();
        check_eq("C_empty", 32'(det_valid), 32'd0);

        // D: pop coincides with push into full FIFO at (4,0)
        start_scan();
        wait_start_at(4, 0, "D_find_40");
        repeat (4) @(negedge clk);
        det_ready = 1'b1;
        @(negedge clk);
        det_ready = 1'b0;
        wait_done("D_done_seen");
        check_eq("D_dropcnt", 32'(drop_count), 32'd3);
        check_eq("D_detcnt", 32'(det_count), 32'd3);
        check_eq("D_h0_x", 32'(det_x), 32'd2);
        check_eq("D_h0_score", 32'(det_score), 32'd201);
        pop_one();
        check_eq("D_h1_valid", 32'(det_valid), 32'd1);
        check_eq("D_h1_x", 32'(det_x), 32'd4);
        check_eq("D_h1_score", 32'(det_score), 32'd401);
        pop_one();
        check_eq("D_empty", 32'(det_valid), 32'd0);

        // E: abort while (2,0) is in flight
        base_win = n_win; base_done = n_done;
        start_scan();
        wait_start_at(2, 0, "E_find_20");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("E_done_seen");
        check_eq("E_aborted", 32'(aborted), 32'd1);
        check_eq("E_wincnt", 32'(win_count), 32'd2);
        check_eq("E_detcnt", 32'(det_count), 32'd2);
        repeat (20) @(negedge clk);
        check_eq("E_nwin", 32'(n_win - base_win), 32'd2);
        check_eq("E_done_pulses", 32'(n_done - base_done), 32'd1);

        // F: reset in the middle of a wait, then rescan from the origin
        pass_mode = 0;
        start_scan();
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("F_busy", 32'(busy), 32'd0);
        check_eq("F_aborted", 32'(aborted), 32'd0);
        check_eq("F_detvalid", 32'(det_valid), 32'd0);
        check_eq("F_detcnt", 32'(det_count), 32'd0);
        check_eq("F_wincnt", 32'(win_count), 32'd0);
        repeat (6) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        base_win = n_win;
        start_scan();
        check_eq("F_restart", 32'(eval_start), 32'd1);
        check_eq("F_x0", 32'(eval_win_x), 32'd0);
        check_eq("F_y0", 32'(eval_win_y), 32'd0);
        wait_done("F_done_seen");
        check_eq("F_wincnt_end", 32'(win_count), 32'd6);
        check_eq("F_nwin", 32'(n_win - base_win), 32'd6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
